// File: rtl/code_serializer_v_pkg.sv
// Shared definitions for the selected-code path (selector, serializer and
// later stages): code width, bit-period counter width and the serializer
// FSM state encoding.
package code_serializer_v_pkg;

    localparam int CODE_W    = 8;
    localparam int BIT_CNT_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

endpackage

// File: rtl/code_serializer_v_baud_tick.sv
// baud_tick_v: bit-period counter for the code serializer.
// Counts 0..CLKS_PER_BIT-1 and flags the last cycle of each serial bit.
//   i_clk   system clock
//   i_rst   asynchronous active-high reset
//   i_clr   hold the counter at 0 (serializer idle)
//   o_tick  high on the last cycle of the current bit
module baud_tick_v
    import code_serializer_v_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    output logic o_tick
);

    localparam logic [BIT_CNT_W-1:0] LAST = BIT_CNT_W'(CLKS_PER_BIT - 1);

    logic [BIT_CNT_W-1:0] r_cnt;
    logic                 w_last;

    assign w_last = (r_cnt == LAST);
    assign o_tick = w_last && !i_clr;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr || w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/code_serializer_v.sv
// code_serializer_v: takes one 8-bit code per valid/ready handshake and sends
// it as start, 8 data bits MSB-first, optional even parity, stop.
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_code, i_valid   code from the selector and its valid flag
//   o_ready           a code can be accepted this cycle
//   o_tx              serial line, idles high
//   o_busy            frame in progress
//   o_done            single-cycle pulse right after the stop bit
//
// state  | meaning
// IDLE   | line high, waiting for a code
// START  | start bit (low)
// DATA   | data bits, MSB of the shift register on the line
// PARITY | even parity of the captured code
// STOP   | stop bit (high)
module code_serializer_v
    import code_serializer_v_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [CODE_W-1:0] i_code,
    input  logic              i_valid,
    output logic              o_ready,
    output logic              o_tx,
    output logic              o_busy,
    output logic              o_done
);

    state_t              r_state;
    state_t              w_next;
    logic [CODE_W-1:0]   r_shift;
    logic [2:0]          r_idx;
    logic                r_parity;
    logic                r_tx;
    logic                r_ready;
    logic                r_busy;
    logic                r_done;
    logic                w_tick;
    logic                w_accept;
    logic                w_idle;
    logic                w_tx_next;

    // r_ready is only ever high while the FSM is idle
    assign w_accept = i_valid && r_ready;
    assign w_idle   = (r_state == ST_IDLE);

    baud_tick_v #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_tick (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clr  (w_idle),
        .o_tick (w_tick)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept) w_next = ST_START;
            ST_START:  if (w_tick) w_next = ST_DATA;
            ST_DATA:   if (w_tick && (r_idx == 3'd7))
                           w_next = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
            ST_PARITY: if (w_tick) w_next = ST_STOP;
            ST_STOP:   if (w_tick) w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so the line changes on the
    // same edge as the state. Inside DATA a bit boundary exposes the bit that
    // the shift is about to move into the MSB.
    always_comb begin
        w_tx_next = 1'b1;
        case (w_next)
            ST_START:  w_tx_next = 1'b0;
            ST_DATA:   w_tx_next = ((r_state == ST_DATA) && w_tick) ?
                                   r_shift[CODE_W-2] : r_shift[CODE_W-1];
            ST_PARITY: w_tx_next = r_parity;
            default:   w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_shift  <= '0;
            r_idx    <= '0;
            r_parity <= 1'b0;
            r_tx     <= 1'b1;
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_shift  <= i_code;
                r_parity <= ^i_code;
            end else if ((r_state == ST_DATA) && w_tick) begin
                r_shift <= {r_shift[CODE_W-2:0], 1'b0};
                // 3-bit index rolls 7->0 exactly when DATA is left
                r_idx   <= r_idx + 3'd1;
            end
            r_tx    <= w_tx_next;
            r_ready <= (w_next == ST_IDLE);
            r_busy  <= (w_next != ST_IDLE);
            r_done  <= (w_next == ST_IDLE) && (r_state == ST_STOP);
        end
    end

    assign o_tx    = r_tx;
    assign o_ready = r_ready;
    assign o_busy  = r_busy;
    assign o_done  = r_done;

endmodule

// File: tb/tb_code_serializer_v.sv
module tb_code_serializer_v;

    logic       clk;
    logic       rst;
    logic [7:0] a_code, c_code;
    logic       a_valid, c_valid;
    logic       a_ready, a_tx, a_busy, a_done;
    logic       c_ready, c_tx, c_busy, c_done;

    int n_vec = 0;
    int n_err = 0;

    logic q_a[$];
    logic q_c[$];

    code_serializer_v #(.CLKS_PER_BIT(4), .PARITY_EN(1)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_code  (a_code),
        .i_valid (a_valid),
        .o_ready (a_ready),
        .o_tx    (a_tx),
        .o_busy  (a_busy),
        .o_done  (a_done)
    );

    code_serializer_v #(.CLKS_PER_BIT(1), .PARITY_EN(0)) dut_c (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_code  (c_code),
        .i_valid (c_valid),
        .o_ready (c_ready),
        .o_tx    (c_tx),
        .o_busy  (c_busy),
        .o_done  (c_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference frame model: each line level repeated cpb times.
    task automatic push_frame(input logic [7:0] d, input int cpb, input bit par_en, input bit to_c);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 7; i >= 0; i--) bits.push_back(d[i]);
        if (par_en) bits.push_back(^d);
        bits.push_back(1'b1);
        foreach (bits[k]) begin
            for (int r = 0; r < cpb; r++) begin
                if (to_c) q_c.push_back(bits[k]);
                else      q_a.push_back(bits[k]);
            end
        end
    endtask

    // Waits for ready, presents the code for one edge; returns in cycle 1.
    task automatic accept_a(input logic [7:0] d);
        int waitc = 0;
        while (a_ready !== 1'b1 && waitc < 200) begin
            @(posedge clk); #1;
            waitc++;
        end
        if (a_ready !== 1'b1) begin
            n_vec++; n_err++;
            $display("FAIL accept_timeout: ready=%b want 1", a_ready);
        end
        a_code  = d;
        a_valid = 1'b1;
        push_frame(d, 4, 1'b1, 1'b0);
        @(posedge clk); #1;
        a_valid = 1'b0;
    endtask

    task automatic test_reset();
        n_vec++;
        if ({a_tx, a_ready, a_busy, a_done} !== 4'b1100) begin
            n_err++;
            $display("FAIL reset_a: tx/ready/busy/done=%b want 1100", {a_tx, a_ready, a_busy, a_done});
        end
        n_vec++;
        if ({c_tx, c_ready, c_busy, c_done} !== 4'b1100) begin
            n_err++;
            $display("FAIL reset_c: tx/ready/busy/done=%b want 1100", {c_tx, c_ready, c_busy, c_done});
        end
    endtask

    task automatic test_basic();
        logic e_tx;
        accept_a(8'h80);
        for (int c = 1; c <= 44; c++) begin
            e_tx = (q_a.size() > 0) ? q_a.pop_front() : 1'bx;
            n_vec++;
            if (a_tx !== e_tx) begin
                n_err++;
                $display("FAIL basic_tx cycle %0d: got %b want %b", c, a_tx, e_tx);
            end
            n_vec++;
            if ({a_ready, a_busy, a_done} !== 3'b010) begin
                n_err++;
                $display("FAIL basic_flags cycle %0d: ready/busy/done=%b want 010", c, {a_ready, a_busy, a_done});
            end
            @(posedge clk); #1;
        end
        n_vec++;
        if ({a_tx, a_ready, a_busy, a_done} !== 4'b1101) begin
            n_err++;
            $display("FAIL basic_done cycle 45: tx/ready/busy/done=%b want 1101", {a_tx, a_ready, a_busy, a_done});
        end
        @(posedge clk); #1;
        n_vec++;
        if (a_done !== 1'b0) begin
            n_err++;
            $display("FAIL basic_done_pulse cycle 46: done=%b want 0", a_done);
        end
    endtask

    task automatic test_parity();
        logic [7:0] codes [2];
        logic       pexp  [2];
        logic       e_tx;
        codes[0] = 8'hC0; pexp[0] = 1'b0;
        codes[1] = 8'h20; pexp[1] = 1'b1;
        for (int f = 0; f < 2; f++) begin
            accept_a(codes[f]);
            for (int c = 1; c <= 44; c++) begin
                e_tx = (q_a.size() > 0) ? q_a.pop_front() : 1'bx;
                n_vec++;
                if (a_tx !== e_tx) begin
                    n_err++;
                    $display("FAIL parity_tx code %h cycle %0d: got %b want %b", codes[f], c, a_tx, e_tx);
                end
                if (c == 38) begin
                    n_vec++;
                    if (a_tx !== pexp[f]) begin
                        n_err++;
                        $display("FAIL parity_bit code %h: got %b want %b", codes[f], a_tx, pexp[f]);
                    end
                end
                @(posedge clk); #1;
            end
            n_vec++;
            if ({a_ready, a_done} !== 2'b11) begin
                n_err++;
                $display("FAIL parity_done code %h: ready/done=%b want 11", codes[f], {a_ready, a_done});
            end
        end
    endtask

    task automatic test_back_to_back();
        logic e_tx;
        logic e_rdy;
        int   ready_cnt = 0;
        int   waitc = 0;
        while (a_ready !== 1'b1 && waitc < 200) begin
            @(posedge clk); #1;
            waitc++;
        end
        a_code  = 8'h40;
        a_valid = 1'b1;
        push_frame(8'h40, 4, 1'b1, 1'b0);
        q_a.push_back(1'b1);
        push_frame(8'hC0, 4, 1'b1, 1'b0);
        @(posedge clk); #1;
        a_code = 8'hC0;
        for (int c = 1; c <= 89; c++) begin
            e_tx  = (q_a.size() > 0) ? q_a.pop_front() : 1'bx;
            e_rdy = (c == 45);
            n_vec++;
            if (a_tx !== e_tx) begin
                n_err++;
                $display("FAIL b2b_tx cycle %0d: got %b want %b", c, a_tx, e_tx);
            end
            n_vec++;
            if ({a_ready, a_busy, a_done} !== {e_rdy, ~e_rdy, e_rdy}) begin
                n_err++;
                $display("FAIL b2b_flags cycle %0d: ready/busy/done=%b want %b", c, {a_ready, a_busy, a_done}, {e_rdy, ~e_rdy, e_rdy});
            end
            if (a_ready === 1'b1) ready_cnt++;
            if (c == 46) a_valid = 1'b0;
            @(posedge clk); #1;
        end
        n_vec++;
        if ({a_tx, a_ready, a_busy, a_done} !== 4'b1101) begin
            n_err++;
            $display("FAIL b2b_done2: tx/ready/busy/done=%b want 1101", {a_tx, a_ready, a_busy, a_done});
        end
        n_vec++;
        if (ready_cnt != 1) begin
            n_err++;
            $display("FAIL b2b_ready_gap: ready cycles between frames=%0d want 1", ready_cnt);
        end
        a_valid = 1'b0;
    endtask

    task automatic test_isolation();
        logic e_tx;
        accept_a(8'h3C);
        for (int c = 1; c <= 44; c++) begin
            if (c == 10) begin a_code = 8'hFF; a_valid = 1'b1; end
            if (c == 20) a_valid = 1'b0;
            e_tx = (q_a.size() > 0) ? q_a.pop_front() : 1'bx;
            n_vec++;
            if ({a_tx, a_ready, a_busy} !== {e_tx, 2'b01}) begin
                n_err++;
                $display("FAIL iso_cycle %0d: tx/ready/busy=%b want %b", c, {a_tx, a_ready, a_busy}, {e_tx, 2'b01});
            end
            @(posedge clk); #1;
        end
        n_vec++;
        if ({a_ready, a_done} !== 2'b11) begin
            n_err++;
            $display("FAIL iso_done: ready/done=%b want 11", {a_ready, a_done});
        end
        for (int c = 46; c <= 50; c++) begin
            @(posedge clk); #1;
            n_vec++;
            if ({a_tx, a_busy, a_done} !== 3'b100) begin
                n_err++;
                $display("FAIL iso_no_extra cycle %0d: tx/busy/done=%b want 100", c, {a_tx, a_busy, a_done});
            end
        end
    endtask

    task automatic test_reset_mid();
        logic e_tx;
        int   bad = 0;
        accept_a(8'h5A);
        for (int c = 1; c <= 18; c++) begin
            e_tx = (q_a.size() > 0) ? q_a.pop_front() : 1'bx;
            n_vec++;
            if (a_tx !== e_tx) begin
                n_err++;
                $display("FAIL rstmid_tx cycle %0d: got %b want %b", c, a_tx, e_tx);
            end
            if (c < 18) begin
                @(posedge clk); #1;
            end
        end
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if ({a_tx, a_ready, a_busy, a_done} !== 4'b1100) begin
            n_err++;
            $display("FAIL rstmid_async: tx/ready/busy/done=%b want 1100", {a_tx, a_ready, a_busy, a_done});
        end
        q_a.delete();
        @(posedge clk); #1;
        #3 rst = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk); #1;
            if ({a_tx, a_busy, a_done} !== 3'b100) bad++;
        end
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL rstmid_quiet: %0d cycles with tx/busy/done off idle, want 0", bad);
        end
        accept_a(8'hA5);
        for (int c = 1; c <= 44; c++) begin
            e_tx = (q_a.size() > 0) ? q_a.pop_front() : 1'bx;
            n_vec++;
            if (a_tx !== e_tx) begin
                n_err++;
                $display("FAIL rstmid_new_tx cycle %0d: got %b want %b", c, a_tx, e_tx);
            end
            @(posedge clk); #1;
        end
        n_vec++;
        if ({a_ready, a_done} !== 2'b11) begin
            n_err++;
            $display("FAIL rstmid_new_done: ready/done=%b want 11", {a_ready, a_done});
        end
    endtask

    task automatic test_corner();
        logic [7:0] codes [2];
        logic [9:0] req;
        logic       e_tx;
        int         waitc;
        codes[0] = 8'hA5;
        codes[1] = 8'h3C;
        req = 10'b0101001011;
        for (int f = 0; f < 2; f++) begin
            waitc = 0;
            while (c_ready !== 1'b1 && waitc < 50) begin
                @(posedge clk); #1;
                waitc++;
            end
            if (c_ready !== 1'b1) begin
                n_vec++; n_err++;
                $display("FAIL corner_accept_timeout: ready=%b want 1", c_ready);
            end
            c_code  = codes[f];
            c_valid = 1'b1;
            push_frame(codes[f], 1, 1'b0, 1'b1);
            @(posedge clk); #1;
            c_valid = 1'b0;
            for (int c = 1; c <= 10; c++) begin
                e_tx = (q_c.size() > 0) ? q_c.pop_front() : 1'bx;
                n_vec++;
                if ({c_tx, c_ready, c_busy, c_done} !== {e_tx, 3'b010}) begin
                    n_err++;
                    $display("FAIL corner_cycle code %h cycle %0d: tx/ready/busy/done=%b want %b", codes[f], c, {c_tx, c_ready, c_busy, c_done}, {e_tx, 3'b010});
                end
                if (f == 0) begin
                    n_vec++;
                    if (c_tx !== req[10-c]) begin
                        n_err++;
                        $display("FAIL corner_a5_seq cycle %0d: got %b want %b", c, c_tx, req[10-c]);
                    end
                end
                @(posedge clk); #1;
            end
            n_vec++;
            if ({c_tx, c_ready, c_busy, c_done} !== 4'b1101) begin
                n_err++;
                $display("FAIL corner_done code %h cycle 11: tx/ready/busy/done=%b want 1101", codes[f], {c_tx, c_ready, c_busy, c_done});
            end
        end
    endtask

    initial begin
        rst     = 1'b0;
        a_code  = 8'h00;
        c_code  = 8'h00;
        a_valid = 1'b0;
        c_valid = 1'b0;
        #1 rst = 1'b1;
        #13;
        test_reset();
        #10 rst = 1'b0;
        @(posedge clk); #1;
        test_basic();
        test_parity();
        test_back_to_back();
        test_isolation();
        test_reset_mid();
        test_corner();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
